// File: rtl/binary_to_ieee_if.sv
// Operand/result handshake bundle for the integer-to-float converter.
interface binary_to_ieee_if;
  localparam int unsigned DATA_W = 32;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;

  // Producer/consumer side: drives operands, takes results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  // Converter side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/binary_to_ieee.sv
// 32-bit integer to IEEE-754 single-precision converter.
// Normalises by shifting one bit per cycle, then rounds to nearest-even.
module binary_to_ieee #(
  parameter bit SIGNED_IN = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  binary_to_ieee_if.slave bus
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHIFT_W = 5;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } ieee_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   m_q, m_d;
  logic [SHIFT_W-1:0]  s_q, s_d;
  logic                sign_q, sign_d;
  ieee_t               res_q, res_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic                sign_in_c;
  logic [DATA_W-1:0]   mag_in_c;
  logic                lsb_c, guard_c, sticky_c, round_up_c;
  logic [FRAC_W:0]     frac_sum_c;
  logic [EXP_W-1:0]    exp_base_c;
  ieee_t               rnd_res_c;

  // Operand sign and magnitude; negating -2^31 wraps to 0x80000000, which is the correct magnitude.
  always_comb begin
    sign_in_c = bus.in_data[DATA_W-1] & SIGNED_IN;
    mag_in_c  = sign_in_c ? (~bus.in_data + DATA_W'(1)) : bus.in_data;
  end

  // Round-to-nearest-even of the normalised magnitude; a fraction carry bumps the exponent.
  always_comb begin
    lsb_c      = m_q[8];
    guard_c    = m_q[7];
    sticky_c   = |m_q[6:0];
    round_up_c = guard_c & (sticky_c | lsb_c);
    frac_sum_c = {1'b0, m_q[DATA_W-2:8]} + (FRAC_W+1)'(round_up_c);
    exp_base_c = EXP_W'(9'd158 - 9'(s_q));
    rnd_res_c.sign = sign_q;
    rnd_res_c.exp  = frac_sum_c[FRAC_W] ? (exp_base_c + EXP_W'(1)) : exp_base_c;
    rnd_res_c.frac = frac_sum_c[FRAC_W-1:0];
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    sign_d  = sign_q;
    res_d   = res_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d = sign_in_c;
          m_d    = mag_in_c;
          s_d    = '0;
          if (mag_in_c == '0) begin
            res_d   = '0;
            state_d = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (m_q[DATA_W-1]) begin
          state_d = ROUND;
        end else begin
          m_d = {m_q[DATA_W-2:0], 1'b0};
          s_d = s_q + SHIFT_W'(1);
        end
      end
      ROUND: begin
        res_d   = rnd_res_c;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake/status outputs registered from the next state.
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      m_q         <= '0;
      s_q         <= '0;
      sign_q      <= 1'b0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      s_q         <= s_d;
      sign_q      <= sign_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = res_q;
  assign bus.busy      = busy_q;

endmodule
